hsst_prefetch_fifo_sync: RTL and testbench
==========================================

Name: hsst_prefetch_fifo_sync

Overview:
- Single-clock, first-word-fall-through (prefetch) FIFO for the HSST/DDR datapath.
- Parametrised in depth and width, with optional write-to-read width upsizing (RATIO words packed per read beat).
- Provides programmable almost-full/almost-empty flags and an occupancy count.
- Sits between the HSST receive word stream and the DDR write-burst packer, where both sides share one clock.

Parameters:
- DEPTH_WIDTH, 11, log2 of capacity in write words (range 4..16); capacity = 2**DEPTH_WIDTH.
- WR_DATA_WIDTH, 16, write word width (1..256).
- RATIO, 1, write words per read beat; legal values 1, 2, 4. RD width = WR_DATA_WIDTH*RATIO.
- AFULL_TH, 2**DEPTH_WIDTH-4, almost_full asserted when count >= AFULL_TH.
- AEMPTY_TH, 4, almost_empty asserted when count <= AEMPTY_TH.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset, synchronous, active-low.
- wr_en  input  1  write request.
- wr_data  input  WR_DATA_WIDTH  write word.
- wr_vld  output  1  space available for one write word; a write is accepted when wr_en & wr_vld.
- rd_en  input  1  read/pop request.
- rd_data  output  WR_DATA_WIDTH*RATIO  prefetched read beat; first-written word in the LSBs.
- rd_vld  output  1  rd_data holds a valid beat; a pop occurs when rd_en & rd_vld.
- count  output  DEPTH_WIDTH+1  stored write words, including the prefetch register.
- almost_full  output  1  registered flag.
- almost_empty  output  1  registered flag.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - pointers, count and prefetch register cleared;
  - rd_data=0, rd_vld=0, count=0, almost_empty=1, almost_full=0;
  - wr_vld=0 while rst_n=0, and 1 from the first edge after release.
  - A reset mid-operation discards all content, including a beat held on rd_data.
- Storage:
  - RAM of 2**DEPTH_WIDTH/RATIO rows × RD width, with lane write select.
  - Write pointer counts in write words, read pointer in beats; both have an extra wrap bit.
  - Full/empty are derived from pointer equality plus the wrap bit.
- Write side:
  - wr_vld = (count <= capacity-1) registered, i.e. 0 exactly when full.
  - wr_en while wr_vld=0 is ignored; data is dropped and no state changes.
  - A write at full is refused even if a pop occurs on the same edge; there is no pass-through.
- Read side (prefetch):
  - The internal RAM read takes 1 cycle; a 1-entry output register holds the head beat.
  - A beat becomes readable once all RATIO lanes of a row are written.
  - Latency: rd_vld rises on the 2nd edge after the write edge that completes a row into an empty FIFO.
  - Pop with a further complete row stored: rd_vld stays 1 and the next beat appears on the following edge (back-to-back 1 beat/cycle).
  - rd_en while rd_vld=0 is ignored.
  - rd_data is held stable while rd_vld=1 & rd_en=0.
- Count:
  - +1 per accepted write, −RATIO per pop; both on the same edge gives +1−RATIO.
  - A partially filled row counts but cannot be read.
- Flags: almost_full/almost_empty are recomputed from the next-state count, so they update on the same edge as count.
- Wrap-around: pointers wrap modulo capacity; the full→empty→full sequence is repeated without a gap.

Optional Feature:
- Macro HSST_FIFO_ERR_FLAG_EN. When defined, adds outputs ovf and udf (1 bit each).
  - ovf: sticky, set on wr_en & !wr_vld.
  - udf: sticky, set on rd_en & !rd_vld.
  - Both cleared only by reset; reset value 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hsst_fifo_pkg holds:
  - RATIO legality check constant;
  - function clog2;
  - localparams for row count and pointer widths;
  - typedef of the count type.
- One sub-module: hsst_fifo_sdp_ram — simple dual-port RAM with 1-cycle registered read and per-lane write enable.

Test Plan:
- Reset/basic, RATIO=1: write 0x0001..0x0003 on consecutive cycles into an empty FIFO → rd_vld=1 two edges after the first write, with rd_data=0x0001; popping each cycle yields 0x0002, 0x0003, then rd_vld=0 and count=0.
- Full boundary, DEPTH_WIDTH=4: write 16 words → wr_vld=0 and count=16; a 17th wr_en plus a simultaneous pop → write refused, count=15, and wr_vld=1 on the next edge.
- Width upsizing, RATIO=2: write 0xAAAA then 0x5555 → rd_data=0x5555AAAA; after only 0xAAAA, rd_vld stays 0 and count=1.
- Thresholds, AFULL_TH=12 and AEMPTY_TH=4, DEPTH_WIDTH=4: fill to 12 → almost_full rises on the same edge count becomes 12; drain to 4 → almost_empty=1.
- Reset mid-operation: with 8 words stored and rd_vld=1, pulse rst_n=0 for 1 cycle → rd_vld=0, count=0, wr_vld=0 during reset and 1 afterwards; old data is never seen.
- With HSST_FIFO_ERR_FLAG_EN: rd_en on an empty FIFO → udf=1 and held; write at full → ovf=1; both cleared only by reset.

Source files
------------

// File: rtl/hsst_prefetch_fifo_sync_pkg.sv
// Purpose: shared helpers, limits and types for the HSST prefetch FIFO.
// Latency: none; elaboration-time constants and functions only.
// Backpressure: not applicable.
package hsst_fifo_pkg;

  localparam int MIN_DEPTH_WIDTH = 4;
  localparam int MAX_DEPTH_WIDTH = 16;
  localparam int MAX_RATIO       = 4;

  // Wide enough for the occupancy of the largest legal FIFO.
  typedef logic [MAX_DEPTH_WIDTH:0] count_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Only power-of-two packing factors up to MAX_RATIO keep rows aligned to the word pointer.
  function automatic bit ratio_is_legal(input int ratio);
    return (ratio == 1) || (ratio == 2) || (ratio == MAX_RATIO);
  endfunction

  function automatic int row_count(input int depth_width, input int ratio);
    return (1 << depth_width) / ratio;
  endfunction

  function automatic int row_addr_width(input int depth_width, input int ratio);
    return depth_width - clog2(ratio);
  endfunction

endpackage

// File: rtl/hsst_prefetch_fifo_sync_if.sv
// Purpose: write/read handshake and status bundle of the HSST prefetch FIFO.
// Latency: none; wires only. Optional ovf/udf under HSST_FIFO_ERR_FLAG_EN.
// Backpressure: wr_vld throttles the writer, rd_vld qualifies each read beat.
interface hsst_prefetch_fifo_sync_if #(
  parameter int DEPTH_WIDTH   = 11,
  parameter int WR_DATA_WIDTH = 16,
  parameter int RATIO         = 1
);
  logic                             wr_en;
  logic [WR_DATA_WIDTH-1:0]         wr_data;
  logic                             wr_vld;
  logic                             rd_en;
  logic [WR_DATA_WIDTH*RATIO-1:0]   rd_data;
  logic                             rd_vld;
  logic [DEPTH_WIDTH:0]             count;
  logic                             almost_full;
  logic                             almost_empty;
`ifdef HSST_FIFO_ERR_FLAG_EN
  logic                             ovf;
  logic                             udf;

  modport master (output wr_en, wr_data, rd_en,
                  input  wr_vld, rd_data, rd_vld, count, almost_full, almost_empty, ovf, udf);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output wr_vld, rd_data, rd_vld, count, almost_full, almost_empty, ovf, udf);
`else
  modport master (output wr_en, wr_data, rd_en,
                  input  wr_vld, rd_data, rd_vld, count, almost_full, almost_empty);
  modport slave  (input  wr_en, wr_data, rd_en,
                  output wr_vld, rd_data, rd_vld, count, almost_full, almost_empty);
`endif
endinterface

// File: rtl/hsst_prefetch_fifo_sync_sdp_ram.sv
// Purpose: simple dual-port row RAM with per-lane write enables.
// Latency: read data registered, valid 1 cycle after rd_en.
// Backpressure: none; the caller guarantees address safety.
module hsst_fifo_sdp_ram #(
  parameter int ADDR_W = 4,
  parameter int ROWS   = 16,
  parameter int LANE_W = 16,
  parameter int LANES  = 1
)(
  input  logic                      clk,
  input  logic [LANES-1:0]          wr_lane_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [LANE_W-1:0]         wr_data,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic [LANES*LANE_W-1:0]   rd_data
);
  logic [LANES*LANE_W-1:0] mem [ROWS];
  logic [LANES*LANE_W-1:0] rd_data_q;

  // Lane-granular write of one word; whole-row registered read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane_en[i]) mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data;
    end
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/hsst_prefetch_fifo_sync.sv
// Purpose: single-clock FWFT FIFO packing RATIO write words per read beat; ovf/udf under HSST_FIFO_ERR_FLAG_EN.
// Latency: rd_vld rises 2 edges after the write completing a row into an empty FIFO; 1 beat/cycle thereafter.
// Backpressure: wr_vld low exactly when full (no pass-through); pops only while rd_vld.
module hsst_prefetch_fifo_sync
  import hsst_fifo_pkg::*;
#(
  parameter int DEPTH_WIDTH   = 11,
  parameter int WR_DATA_WIDTH = 16,
  parameter int RATIO         = 1,
  parameter int AFULL_TH      = 2**DEPTH_WIDTH - 4,
  parameter int AEMPTY_TH     = 4
)(
  input  logic                      clk,
  input  logic                      rst_n,
  hsst_prefetch_fifo_sync_if.slave  bus
);
  localparam int CAP  = 2**DEPTH_WIDTH;
  localparam int CW   = DEPTH_WIDTH + 1;
  localparam int LB   = clog2(RATIO);
  localparam int ROWS = row_count(DEPTH_WIDTH, RATIO);
  localparam int RAW  = row_addr_width(DEPTH_WIDTH, RATIO);
  localparam int RD_W = WR_DATA_WIDTH * RATIO;

  if (!ratio_is_legal(RATIO) || DEPTH_WIDTH < MIN_DEPTH_WIDTH || DEPTH_WIDTH > MAX_DEPTH_WIDTH) begin : g_bad_cfg
    $error("hsst_prefetch_fifo_sync: RATIO must be 1/2/4 and DEPTH_WIDTH 4..16");
  end

  logic [DEPTH_WIDTH:0] wr_ptr_q, wr_ptr_d;    // write words, extra wrap bit
  logic [RAW:0]         rd_ptr_q, rd_ptr_d;    // rows fetched from RAM, extra wrap bit
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ram_vld_q, ram_vld_d;  // RAM output register holds the next beat
  logic                 rd_vld_q, rd_vld_d;    // prefetch register holds the head beat
  logic [RD_W-1:0]      rd_data_q, rd_data_d;
  logic                 wr_vld_q, wr_vld_d;
  logic                 af_q, af_d, ae_q, ae_d;
  logic                 wr_vld, wr_acc, pop, row_avail, out_load, ram_rd;
  logic [RATIO-1:0]     lane_we;
  logic [RD_W-1:0]      ram_dout;

  // Held low for the whole reset cycle, not only after the reset edge.
  assign wr_vld = wr_vld_q & rst_n;

  // Two-stage prefetch (RAM register, then head register), pointers, count and flags.
  always_comb begin
    wr_acc    = bus.wr_en & wr_vld;
    pop       = bus.rd_en & rd_vld_q;
    // An unfetched complete row exists when the write row pointer has moved past the fetch pointer.
    row_avail = (wr_ptr_q[DEPTH_WIDTH:LB] != rd_ptr_q);
    out_load  = ram_vld_q & (~rd_vld_q | pop);
    ram_rd    = row_avail & (~ram_vld_q | out_load);
    lane_we   = '0;
    for (int i = 0; i < RATIO; i++) begin
      lane_we[i] = wr_acc && ((int'(wr_ptr_q) % RATIO) == i);
    end
    wr_ptr_d  = wr_ptr_q + CW'(wr_acc);
    rd_ptr_d  = rd_ptr_q + (RAW+1)'(ram_rd);
    ram_vld_d = ram_rd | (ram_vld_q & ~out_load);
    rd_vld_d  = out_load | (rd_vld_q & ~pop);
    rd_data_d = out_load ? ram_dout : rd_data_q;
    cnt_d     = cnt_q + CW'(wr_acc) - (pop ? CW'(RATIO) : CW'(0));
    wr_vld_d  = (cnt_d <= CW'(CAP - 1));
    af_d      = (count_t'(cnt_d) >= count_t'(AFULL_TH));
    ae_d      = (count_t'(cnt_d) <= count_t'(AEMPTY_TH));
  end

`ifdef HSST_FIFO_ERR_FLAG_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky misuse flags: write without space, read without data.
  always_comb begin
    ovf_d = ovf_q | (bus.wr_en & ~wr_vld);
    udf_d = udf_q | (bus.rd_en & ~rd_vld_q);
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif

  // State register; reset discards everything including the held head beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      ram_vld_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
      wr_vld_q  <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
`ifdef HSST_FIFO_ERR_FLAG_EN
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      ram_vld_q <= ram_vld_d;
      rd_vld_q  <= rd_vld_d;
      rd_data_q <= rd_data_d;
      wr_vld_q  <= wr_vld_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
`ifdef HSST_FIFO_ERR_FLAG_EN
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
`endif
    end
  end

  hsst_fifo_sdp_ram #(
    .ADDR_W (RAW),
    .ROWS   (ROWS),
    .LANE_W (WR_DATA_WIDTH),
    .LANES  (RATIO)
  ) u_ram (
    .clk        (clk),
    .wr_lane_en (lane_we),
    .wr_addr    (wr_ptr_q[DEPTH_WIDTH-1:LB]),
    .wr_data    (bus.wr_data),
    .rd_en      (ram_rd),
    .rd_addr    (rd_ptr_q[RAW-1:0]),
    .rd_data    (ram_dout)
  );

  assign bus.wr_vld       = wr_vld;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_vld       = rd_vld_q;
  assign bus.count        = cnt_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
endmodule

// File: tb/tb_hsst_prefetch_fifo_sync.sv
// Purpose: directed scoreboard bench for hsst_prefetch_fifo_sync (RATIO=1 and RATIO=2 instances, DEPTH_WIDTH=4).
// Latency: read beats checked by per-instance monitors on the falling edge; status checked 1 time unit after posedge.
// Backpressure: optional ovf/udf checks compile in under HSST_FIFO_ERR_FLAG_EN.
module tb_hsst_prefetch_fifo_sync;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] qa[$];
  logic [31:0] qb[$];
  int   exp_cnt;

  hsst_prefetch_fifo_sync_if #(.DEPTH_WIDTH(4), .WR_DATA_WIDTH(16), .RATIO(1)) bus_a();
  hsst_prefetch_fifo_sync_if #(.DEPTH_WIDTH(4), .WR_DATA_WIDTH(16), .RATIO(2)) bus_b();

  hsst_prefetch_fifo_sync #(
    .DEPTH_WIDTH(4), .WR_DATA_WIDTH(16), .RATIO(1), .AFULL_TH(12), .AEMPTY_TH(4)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  hsst_prefetch_fifo_sync #(
    .DEPTH_WIDTH(4), .WR_DATA_WIDTH(16), .RATIO(2), .AFULL_TH(12), .AEMPTY_TH(4)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor A: every popped beat must be the oldest expected word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_a.rd_vld === 1'b1 && bus_a.rd_en === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_a_extra: got 0x%0h, expected no beat", bus_a.rd_data);
      end else begin
        chk("sb_a_data", 64'(bus_a.rd_data), 64'(qa.pop_front()));
      end
    end
  end

  // Scoreboard monitor B: packed beats, first-written word in the LSBs.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_b.rd_vld === 1'b1 && bus_b.rd_en === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_b_extra: got 0x%0h, expected no beat", bus_b.rd_data);
      end else begin
        chk("sb_b_data", 64'(bus_b.rd_data), 64'(qb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    bus_a.wr_en = 1'b0; bus_a.wr_data = '0; bus_a.rd_en = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_data = '0; bus_b.rd_en = 1'b0;
    repeat (2) step();

    // Reset state
    chk("rst_rd_vld",   64'(bus_a.rd_vld), 64'(0));
    chk("rst_count",    64'(bus_a.count), 64'(0));
    chk("rst_ae",       64'(bus_a.almost_empty), 64'(1));
    chk("rst_af",       64'(bus_a.almost_full), 64'(0));
    chk("rst_wr_vld",   64'(bus_a.wr_vld), 64'(0));
    chk("rst_rd_data",  64'(bus_a.rd_data), 64'(0));
    chk("rst_b_rd_vld", 64'(bus_b.rd_vld), 64'(0));
    chk("rst_b_count",  64'(bus_b.count), 64'(0));
    rst_n = 1'b1;
    step();
    chk("post_rst_wr_vld", 64'(bus_a.wr_vld), 64'(1));

    // Basic FWFT, RATIO=1: three consecutive writes, then pop each cycle
    bus_a.wr_en = 1'b1; bus_a.wr_data = 16'h0001; qa.push_back(16'h0001);
    step();
    chk("t1_vld_e0", 64'(bus_a.rd_vld), 64'(0));
    bus_a.wr_data = 16'h0002; qa.push_back(16'h0002);
    step();
    chk("t1_vld_e1", 64'(bus_a.rd_vld), 64'(0));
    bus_a.wr_data = 16'h0003; qa.push_back(16'h0003);
    step();
    bus_a.wr_en = 1'b0;
    chk("t1_vld_e2", 64'(bus_a.rd_vld), 64'(1));
    chk("t1_head",   64'(bus_a.rd_data), 64'(16'h0001));
    chk("t1_count",  64'(bus_a.count), 64'(3));
    bus_a.rd_en = 1'b1;
    repeat (3) step();
    bus_a.rd_en = 1'b0;
    chk("t1_vld_end",   64'(bus_a.rd_vld), 64'(0));
    chk("t1_count_end", 64'(bus_a.count), 64'(0));
    chk("t1_ae_end",    64'(bus_a.almost_empty), 64'(1));
    chk("t1_sb_left",   64'(qa.size()), 64'(0));

    // Fill to full with threshold tracking; refused write with simultaneous pop; drain back-to-back
    for (int k = 1; k <= 16; k++) begin
      bus_a.wr_en = 1'b1; bus_a.wr_data = 16'h0100 + 16'(k - 1); qa.push_back(16'h0100 + 16'(k - 1));
      step();
      chk("t2_fill_count", 64'(bus_a.count), 64'(k));
      chk("t2_fill_af",    64'(bus_a.almost_full), 64'(k >= 12));
      chk("t2_fill_ae",    64'(bus_a.almost_empty), 64'(k <= 4));
    end
    chk("t2_full_wr_vld", 64'(bus_a.wr_vld), 64'(0));
    bus_a.wr_data = 16'hDEAD;
    bus_a.rd_en = 1'b1;
    step();
    bus_a.wr_en = 1'b0;
    chk("t2_refused_count", 64'(bus_a.count), 64'(15));
    chk("t2_wr_vld_back",   64'(bus_a.wr_vld), 64'(1));
    exp_cnt = 15;
    for (int k = 0; k < 15; k++) begin
      chk("t2_b2b_vld", 64'(bus_a.rd_vld), 64'(1));
      step();
      exp_cnt--;
      chk("t2_drain_count", 64'(bus_a.count), 64'(exp_cnt));
      chk("t2_drain_ae",    64'(bus_a.almost_empty), 64'(exp_cnt <= 4));
      chk("t2_drain_af",    64'(bus_a.almost_full), 64'(exp_cnt >= 12));
    end
    bus_a.rd_en = 1'b0;
    chk("t2_vld_end", 64'(bus_a.rd_vld), 64'(0));
    chk("t2_sb_left", 64'(qa.size()), 64'(0));

    // Reset mid-operation with a valid head beat
    bus_a.wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_a.wr_data = 16'h0200 + 16'(k); qa.push_back(16'h0200 + 16'(k));
      step();
    end
    bus_a.wr_en = 1'b0;
    step();
    step();
    chk("t3_pre_vld",   64'(bus_a.rd_vld), 64'(1));
    chk("t3_pre_count", 64'(bus_a.count), 64'(8));
    rst_n = 1'b0;
    step();
    qa.delete();
    chk("t3_rst_wr_vld",  64'(bus_a.wr_vld), 64'(0));
    chk("t3_rst_rd_vld",  64'(bus_a.rd_vld), 64'(0));
    chk("t3_rst_count",   64'(bus_a.count), 64'(0));
    chk("t3_rst_ae",      64'(bus_a.almost_empty), 64'(1));
    chk("t3_rst_af",      64'(bus_a.almost_full), 64'(0));
    chk("t3_rst_rd_data", 64'(bus_a.rd_data), 64'(0));
    rst_n = 1'b1;
    step();
    chk("t3_rel_wr_vld", 64'(bus_a.wr_vld), 64'(1));
    chk("t3_rel_rd_vld", 64'(bus_a.rd_vld), 64'(0));
    bus_a.wr_en = 1'b1; bus_a.wr_data = 16'h0301; qa.push_back(16'h0301);
    step();
    bus_a.wr_en = 1'b0;
    step();
    chk("t3_new_vld_e1", 64'(bus_a.rd_vld), 64'(0));
    step();
    chk("t3_new_vld",  64'(bus_a.rd_vld), 64'(1));
    chk("t3_new_data", 64'(bus_a.rd_data), 64'(16'h0301));
    bus_a.rd_en = 1'b1;
    step();
    bus_a.rd_en = 1'b0;
    chk("t3_count_end", 64'(bus_a.count), 64'(0));
    chk("t3_sb_left",   64'(qa.size()), 64'(0));

    // Width upsizing, RATIO=2: half row is counted but not readable
    bus_b.wr_en = 1'b1; bus_b.wr_data = 16'hAAAA;
    step();
    bus_b.wr_en = 1'b0;
    chk("t4_half_count", 64'(bus_b.count), 64'(1));
    step();
    step();
    chk("t4_half_vld", 64'(bus_b.rd_vld), 64'(0));
    bus_b.wr_en = 1'b1; bus_b.wr_data = 16'h5555; qb.push_back(32'h5555AAAA);
    step();
    bus_b.wr_en = 1'b0;
    chk("t4_row_count",  64'(bus_b.count), 64'(2));
    chk("t4_row_vld_e0", 64'(bus_b.rd_vld), 64'(0));
    step();
    chk("t4_row_vld_e1", 64'(bus_b.rd_vld), 64'(0));
    step();
    chk("t4_row_vld",  64'(bus_b.rd_vld), 64'(1));
    chk("t4_row_data", 64'(bus_b.rd_data), 64'(32'h5555AAAA));
    bus_b.wr_en = 1'b1; bus_b.wr_data = 16'h2222;
    step();
    bus_b.wr_data = 16'h1111; qb.push_back(32'h11112222);
    step();
    bus_b.wr_en = 1'b0;
    step();
    step();
    chk("t4_count4", 64'(bus_b.count), 64'(4));
    bus_b.rd_en = 1'b1; bus_b.wr_en = 1'b1; bus_b.wr_data = 16'h3333;
    step();
    chk("t4_pop_wr_count", 64'(bus_b.count), 64'(3));
    bus_b.wr_data = 16'h4444; qb.push_back(32'h44443333);
    step();
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0;
    chk("t4_pop_wr_count2", 64'(bus_b.count), 64'(2));
    chk("t4_gap_vld",       64'(bus_b.rd_vld), 64'(0));
    for (int k = 0; k < 10 && bus_b.rd_vld !== 1'b1; k++) step();
    chk("t4_third_vld", 64'(bus_b.rd_vld), 64'(1));
    bus_b.rd_en = 1'b1;
    step();
    bus_b.rd_en = 1'b0;
    chk("t4_count_end", 64'(bus_b.count), 64'(0));
    chk("t4_vld_end",   64'(bus_b.rd_vld), 64'(0));
    chk("t4_sb_left",   64'(qb.size()), 64'(0));

`ifdef HSST_FIFO_ERR_FLAG_EN
    // Sticky misuse flags
    chk("t5_udf_init", 64'(bus_a.udf), 64'(0));
    chk("t5_ovf_init", 64'(bus_a.ovf), 64'(0));
    bus_a.rd_en = 1'b1;
    step();
    bus_a.rd_en = 1'b0;
    chk("t5_udf", 64'(bus_a.udf), 64'(1));
    step();
    chk("t5_udf_hold",  64'(bus_a.udf), 64'(1));
    chk("t5_ovf_clear", 64'(bus_a.ovf), 64'(0));
    bus_a.wr_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      bus_a.wr_data = 16'h0400 + 16'(k);
      step();
    end
    bus_a.wr_en = 1'b0;
    chk("t5_ovf",       64'(bus_a.ovf), 64'(1));
    chk("t5_ovf_count", 64'(bus_a.count), 64'(16));
    step();
    chk("t5_ovf_hold",  64'(bus_a.ovf), 64'(1));
    chk("t5_udf_hold2", 64'(bus_a.udf), 64'(1));
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_ovf_rst", 64'(bus_a.ovf), 64'(0));
    chk("t5_udf_rst", 64'(bus_a.udf), 64'(0));
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
